// File: rtl/ahb_burst_master_ctrl.sv
// AHB-Lite burst master: turns one command into a SINGLE/INCR4/WRAP4 sequence of
// pipelined transfers, with wait-state handling and a consecutive-stall timeout.
module ahb_burst_master_ctrl #(
  parameter int MAX_WAIT = 16
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_burst,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] wdata_in,
  output logic        wdata_pop,
  output logic [31:0] rdata_out,
  output logic        rdata_valid,
  output logic        done,
  output logic        err,
  output logic [31:0] Haddr,
  output logic [31:0] Hwdata,
  output logic        Hwrite,
  output logic [1:0]  Htrans,
  output logic [2:0]  Hsize,
  output logic [2:0]  Hburst,
  output logic        Hreadyin,
  input  logic        Hreadyout,
  input  logic [31:0] Hrdata
);
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_BURST, S_DATA} state_t;

  state_t      state_q;
  logic [1:0]  beats_q;   // address phases still to issue after the current one
  logic [31:0] wait_q;

  logic        addr_phase;
  logic        data_phase;
  logic        timeout;
  logic [2:0]  size_d;
  logic [2:0]  burst_d;
  logic [31:0] step;
  logic [31:0] wrap_mask;
  logic [31:0] next_addr_d;

  always_comb begin
    size_d  = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
    burst_d = (cmd_burst == BURST_INCR4 || cmd_burst == BURST_WRAP4) ? cmd_burst : BURST_SINGLE;
  end

  // Wrapping keeps the bits above the 4-beat window and steps only inside it.
  assign step        = 32'd1 << Hsize;
  assign wrap_mask   = (step << 2) - 32'd1;
  assign next_addr_d = (Hburst == BURST_WRAP4)
                     ? ((Haddr & ~wrap_mask) | ((Haddr + step) & wrap_mask))
                     : (Haddr + step);

  assign addr_phase = (state_q == S_ADDR) || (state_q == S_BURST);
  assign data_phase = (state_q == S_BURST) || (state_q == S_DATA);
  assign timeout    = (MAX_WAIT > 0) && (state_q != S_IDLE) && !Hreadyout &&
                      (wait_q == 32'(MAX_WAIT - 1));

  assign cmd_ready = (state_q == S_IDLE) && !Hreset;
  assign wdata_pop = !Hreset && addr_phase && Hwrite && Hreadyout;

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q     <= S_IDLE;
      beats_q     <= 2'd0;
      wait_q      <= 32'd0;
      Haddr       <= 32'd0;
      Hwdata      <= 32'd0;
      Hwrite      <= 1'b0;
      Htrans      <= TR_IDLE;
      Hsize       <= 3'd0;
      Hburst      <= 3'd0;
      Hreadyin    <= 1'b0;
      rdata_out   <= 32'd0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      Hreadyin    <= 1'b1;
      done        <= 1'b0;
      err         <= 1'b0;
      rdata_valid <= 1'b0;

      if (state_q == S_IDLE || Hreadyout) wait_q <= 32'd0;
      else                                wait_q <= wait_q + 32'd1;

      if (wdata_pop) Hwdata <= wdata_in;

      if (data_phase && Hreadyout && !Hwrite) begin
        rdata_out   <= Hrdata;
        rdata_valid <= 1'b1;
      end

      if (timeout) begin
        state_q <= S_IDLE;
        Htrans  <= TR_IDLE;
        err     <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
              state_q <= S_ADDR;
              Htrans  <= TR_NONSEQ;
              Haddr   <= cmd_addr;
              Hwrite  <= cmd_write;
              Hsize   <= size_d;
              Hburst  <= burst_d;
              beats_q <= (burst_d == BURST_SINGLE) ? 2'd0 : 2'd3;
            end
          end
          S_ADDR, S_BURST: begin
            if (Hreadyout) begin
              if (beats_q == 2'd0) begin
                state_q <= S_DATA;
                Htrans  <= TR_IDLE;
              end else begin
                state_q <= S_BURST;
                Htrans  <= TR_SEQ;
                Haddr   <= next_addr_d;
                beats_q <= beats_q - 2'd1;
              end
            end
          end
          S_DATA: begin
            if (Hreadyout) begin
              state_q <= S_IDLE;
              done    <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule
